// File: rtl/trap_seq_ctrl.sv
// Machine-mode trap/return sequencer: arbitrates trap sources and mret, walks the
// CSR port through mepc/mcause/mtval/mstatus, then issues a single PC redirect.
`timescale 1ns/1ps
module trap_seq_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [1:0]  TRAP_MPP    = 2'b11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            is_illegal,
    input  logic            is_mret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            mstatus_mie,
    output logic            stall,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIR
    } state_t;

    state_t            r_state;
    logic              r_wen;
    logic [11:0]       r_waddr;
    logic [11:0]       r_raddr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_redir;
    logic [XLEN-1:0]   r_cause;
    logic [XLEN-1:0]   r_tval;
    logic              r_mret;

    logic              w_irq_ext;
    logic              w_irq_tmr;
    logic              w_take;
    logic              w_mret;
    logic [XLEN-1:0]   w_cause;
    logic [XLEN-1:0]   w_tval;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_redir_pc;

    always_comb begin
        w_irq_ext = irq_ext & mstatus_mie;
        w_irq_tmr = irq_timer & mstatus_mie;
        w_take    = rst_n & instr_valid & (r_state == IDLE) &
                    (w_irq_ext | w_irq_tmr | is_illegal | is_ebreak | is_ecall | is_mret);
        w_mret    = 1'b0;
        w_cause   = '0;
        w_tval    = '0;
        if (w_irq_ext) begin
            w_cause[XLEN-1] = 1'b1;
            w_cause[3:0]    = 4'hB;
        end else if (w_irq_tmr) begin
            w_cause[XLEN-1] = 1'b1;
            w_cause[3:0]    = 4'h7;
        end else if (is_illegal) begin
            w_cause[3:0] = 4'h2;
            w_tval       = XLEN'(instr);
        end else if (is_ebreak) begin
            w_cause[3:0] = 4'h3;
            w_tval       = pc;
        end else if (is_ecall) begin
            w_cause[3:0] = 4'hB;
        end else begin
            w_mret = is_mret;
        end
    end

    // mstatus and the redirect target depend on same-cycle read data, so they bypass the registers
    always_comb begin
        w_wdata = r_wdata;
        if (r_state == W_STATUS) begin
            w_wdata        = csr_rdata;
            w_wdata[7]     = csr_rdata[3];
            w_wdata[3]     = 1'b0;
            w_wdata[12:11] = TRAP_MPP;
        end else if (r_state == M_STATUS) begin
            w_wdata        = csr_rdata;
            w_wdata[3]     = csr_rdata[7];
            w_wdata[7]     = 1'b1;
            w_wdata[12:11] = TRAP_MPP;
        end
    end

    always_comb begin
        w_base     = {csr_rdata[XLEN-1:2], 2'b00};
        w_redir_pc = '0;
        if (r_state == REDIR) begin
            if (r_mret)
                w_redir_pc = csr_rdata;
            else if (VECTORED_EN && (csr_rdata[1:0] == 2'b01) && r_cause[XLEN-1])
                w_redir_pc = w_base + XLEN'({r_cause[4:0], 2'b00});
            else
                w_redir_pc = w_base;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_raddr <= '0;
            r_wdata <= '0;
            r_redir <= 1'b0;
            r_cause <= '0;
            r_tval  <= '0;
            r_mret  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_cause <= w_cause;
                        r_tval  <= w_tval;
                        r_mret  <= w_mret;
                        r_wen   <= 1'b1;
                        if (w_mret) begin
                            r_state <= M_STATUS;
                            r_waddr <= 12'h300;
                            r_raddr <= 12'h300;
                            r_wdata <= '0;
                        end else begin
                            r_state <= W_EPC;
                            r_waddr <= 12'h341;
                            r_wdata <= {pc[XLEN-1:2], 2'b00};
                        end
                    end
                end
                W_EPC: begin
                    r_state <= W_CAUSE;
                    r_waddr <= 12'h342;
                    r_wdata <= r_cause;
                end
                W_CAUSE: begin
                    r_state <= W_TVAL;
                    r_waddr <= 12'h343;
                    r_wdata <= r_tval;
                end
                W_TVAL: begin
                    r_state <= W_STATUS;
                    r_waddr <= 12'h300;
                    r_raddr <= 12'h300;
                    r_wdata <= '0;
                end
                W_STATUS, M_STATUS: begin
                    r_state <= REDIR;
                    r_wen   <= 1'b0;
                    r_waddr <= '0;
                    r_raddr <= r_mret ? 12'h341 : 12'h305;
                    r_redir <= 1'b1;
                end
                REDIR: begin
                    r_state <= IDLE;
                    r_raddr <= '0;
                    r_redir <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write strobe is gated by reset so a sequence aborted mid-way stops writing immediately
    assign csr_wen        = r_wen & rst_n;
    assign csr_waddr      = r_waddr;
    assign csr_wdata      = w_wdata;
    assign csr_raddr      = r_raddr;
    assign redirect_valid = r_redir;
    assign redirect_pc    = w_redir_pc;
    assign busy           = (r_state != IDLE);
    assign stall          = w_take | busy;

endmodule
